// File: rtl/shadow_write_queue.sv
// Captures CPU writes into shadowed video regions of banks $00/$01 and replays
// them, one per 1 MHz slot, as writes into slow RAM banks $E0/$E1.
module shadow_write_queue #(
    parameter int FIFO_AW = 3
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               cpu_valid,
    input  logic               cpu_we,
    input  logic [7:0]         cpu_bank,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_dout,
    input  logic [7:0]         shadow_reg,
    input  logic               slow_ce,
    input  logic               slow_port_busy,
    output logic [16:0]        slow_addr,
    output logic [7:0]         slow_din,
    output logic               slow_we,
    output logic               cpu_stall,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    logic [24:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count_next;

    logic is_full;
    logic is_empty;
    logic match;
    logic push;
    logic pop;
    logic drop;

    logic in_text1;
    logic in_text2;
    logic in_hires1;
    logic in_hires2;
    logic in_super;
    logic low_bank;
    logic bank_one;
    logic region_ok;

    logic unused_shadow;
    assign unused_shadow = &{1'b0, shadow_reg[7:6]};

    // Region decode: a set shadow_reg bit inhibits shadowing of that region.
    always_comb begin
        in_text1  = (cpu_addr[15:10] == 6'b000001);
        in_text2  = (cpu_addr[15:10] == 6'b000010);
        in_hires1 = (cpu_addr[15:13] == 3'b001);
        in_hires2 = (cpu_addr[15:13] == 3'b010);
        in_super  = (cpu_addr[15:13] == 3'b011) || (cpu_addr[15:13] == 3'b100);
        low_bank  = (cpu_bank[7:1] == 7'd0);
        bank_one  = cpu_bank[0];

        region_ok = 1'b0;
        if (in_text1) begin
            region_ok = ~shadow_reg[0];
        end else if (in_text2) begin
            region_ok = ~shadow_reg[5];
        end else if (in_hires1) begin
            region_ok = bank_one ? ((~shadow_reg[1] & ~shadow_reg[4]) | ~shadow_reg[3])
                                 : ~shadow_reg[1];
        end else if (in_hires2) begin
            region_ok = bank_one ? ((~shadow_reg[2] & ~shadow_reg[4]) | ~shadow_reg[3])
                                 : ~shadow_reg[2];
        end else if (in_super) begin
            region_ok = bank_one & ~shadow_reg[3];
        end

        match = cpu_valid & cpu_we & low_bank & region_ok;
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        is_full  = (fifo_count == FULL_COUNT);
        is_empty = (fifo_count == '0);
        pop      = slow_ce & ~slow_port_busy & ~is_empty;
        push     = match & (~is_full | pop);
        drop     = match & is_full & ~pop;

        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + (FIFO_AW + 1)'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - (FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= {cpu_bank[0], cpu_addr, cpu_dout};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            cpu_stall  <= 1'b0;
            overflow   <= 1'b0;
            slow_addr  <= '0;
            slow_din   <= '0;
            slow_we    <= 1'b0;
        end else begin
            fifo_count <= count_next;
            cpu_stall  <= (count_next == FULL_COUNT);
            slow_we    <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + FIFO_AW'(1);
                slow_addr <= mem[rd_ptr][24:8];
                slow_din  <= mem[rd_ptr][7:0];
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shadow_write_queue.sv
// Self-checking bench for shadow_write_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_shadow_write_queue;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_bank = '0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  shadow_reg = '0;
    logic        slow_ce = 1'b0;
    logic        slow_port_busy = 1'b0;
    logic [16:0] slow_addr;
    logic [7:0]  slow_din;
    logic        slow_we;
    logic        cpu_stall;
    logic [3:0]  fifo_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    bit [24:0]   model_q[$];
    logic [16:0] exp_addr;
    logic [7:0]  exp_din;
    logic        exp_we;
    logic        exp_ovf;

    always #5 clk_sys = ~clk_sys;

    shadow_write_queue #(.FIFO_AW(3)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cpu_valid      (cpu_valid),
        .cpu_we         (cpu_we),
        .cpu_bank       (cpu_bank),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .shadow_reg     (shadow_reg),
        .slow_ce        (slow_ce),
        .slow_port_busy (slow_port_busy),
        .slow_addr      (slow_addr),
        .slow_din       (slow_din),
        .slow_we        (slow_we),
        .cpu_stall      (cpu_stall),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit model_match(input bit v, input bit we, input int bank, input int addr, input bit [7:0] sh);
        if (!v || !we) return 1'b0;
        if (bank != 0 && bank != 1) return 1'b0;
        if (addr >= 'h0400 && addr <= 'h07FF) return !sh[0];
        if (addr >= 'h0800 && addr <= 'h0BFF) return !sh[5];
        if (addr >= 'h2000 && addr <= 'h3FFF)
            return (bank == 0) ? !sh[1] : ((!sh[1] && !sh[4]) || !sh[3]);
        if (addr >= 'h4000 && addr <= 'h5FFF)
            return (bank == 0) ? !sh[2] : ((!sh[2] && !sh[4]) || !sh[3]);
        if (addr >= 'h6000 && addr <= 'h9FFF) return (bank == 1) && !sh[3];
        return 1'b0;
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_addr = '0;
        exp_din  = '0;
        exp_we   = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic model_step();
        bit        m;
        bit        was_full;
        bit        popped;
        bit [24:0] e;
        m        = model_match(cpu_valid, cpu_we, int'(cpu_bank), int'(cpu_addr), shadow_reg);
        was_full = (model_q.size() == 8);
        popped   = slow_ce && !slow_port_busy && (model_q.size() > 0);
        exp_we   = 1'b0;
        if (popped) begin
            e        = model_q.pop_front();
            exp_addr = e[24:8];
            exp_din  = e[7:0];
            exp_we   = 1'b1;
        end
        if (m) begin
            if (!was_full || popped) model_q.push_back({cpu_bank[0], cpu_addr, cpu_dout});
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_output("slow_we", slow_we, exp_we);
        check_output("slow_addr", slow_addr, exp_addr);
        check_output("slow_din", slow_din, exp_din);
        check_output("fifo_count", fifo_count, model_q.size());
        check_output("cpu_stall", cpu_stall, model_q.size() == 8);
        check_output("overflow", overflow, exp_ovf);
    endtask

    task automatic apply_stimulus(input bit v, input bit we, input logic [7:0] bank, input logic [15:0] addr,
                                  input logic [7:0] dout, input logic [7:0] sh, input bit ce, input bit busy);
        @(negedge clk_sys);
        cpu_valid      = v;
        cpu_we         = we;
        cpu_bank       = bank;
        cpu_addr       = addr;
        cpu_dout       = dout;
        shadow_reg     = sh;
        slow_ce        = ce;
        slow_port_busy = busy;
        @(posedge clk_sys);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input bit ce, input bit busy);
        apply_stimulus(1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, shadow_reg, ce, busy);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        cpu_valid = 1'b0;
        slow_ce   = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_slow_we"}, slow_we, 0);
        check_output({tag, "_slow_addr"}, slow_addr, 0);
        check_output({tag, "_slow_din"}, slow_din, 0);
        check_output({tag, "_fifo_count"}, fifo_count, 0);
        check_output({tag, "_cpu_stall"}, cpu_stall, 0);
        check_output({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        int          ce_div;

        model_reset();
        do_reset();
        check_all_zero("reset");

        // Single text-page write drained after a delay.
        apply_stimulus(1, 1, 8'h00, 16'h0400, 8'hA5, 8'h00, 0, 0);
        check_output("t1_count_push", fifo_count, 1);
        idle(0, 0);
        idle(0, 0);
        idle(1, 0);
        check_output("t1_we", slow_we, 1);
        check_output("t1_addr", slow_addr, 17'h00400);
        check_output("t1_din", slow_din, 8'hA5);
        check_output("t1_count_pop", fifo_count, 0);
        idle(0, 0);
        check_output("t1_we_drop", slow_we, 0);

        // Non-matching accesses.
        apply_stimulus(1, 1, 8'h00, 16'h0400, 8'h11, 8'h01, 0, 0);
        apply_stimulus(1, 1, 8'h02, 16'h2000, 8'h22, 8'h01, 0, 0);
        apply_stimulus(1, 0, 8'h00, 16'h2000, 8'h33, 8'h01, 0, 0);
        check_output("t2_count", fifo_count, 0);

        // Bank $01 super-hires region.
        apply_stimulus(1, 1, 8'h01, 16'h8000, 8'h3C, 8'h00, 0, 0);
        idle(1, 0);
        check_output("t3_addr", slow_addr, 17'h18000);
        check_output("t3_din", slow_din, 8'h3C);
        check_output("t3_we", slow_we, 1);
        apply_stimulus(1, 1, 8'h01, 16'h8000, 8'h3C, 8'h08, 0, 0);
        check_output("t3_inhibit_count", fifo_count, 0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 8; i++)
            apply_stimulus(1, 1, 8'h00, 16'h0400 + 16'(i), 8'(i + 8'h40), 8'h00, 0, 0);
        check_output("t4_count_full", fifo_count, 8);
        check_output("t4_stall", cpu_stall, 1);
        apply_stimulus(1, 1, 8'h00, 16'h0480, 8'hFF, 8'h00, 0, 0);
        check_output("t4_overflow", overflow, 1);
        check_output("t4_count_after_drop", fifo_count, 8);
        idle(1, 0);
        check_output("t4_first_addr", slow_addr, 17'h00400);
        check_output("t4_first_din", slow_din, 8'h40);
        for (int i = 0; i < 7; i++) idle(1, 0);
        check_output("t4_last_din", slow_din, 8'h47);
        check_output("t4_stall_clear", cpu_stall, 0);

        // Push while full with coincident pop; busy slot is lost.
        do_reset();
        for (int i = 0; i < 8; i++)
            apply_stimulus(1, 1, 8'h00, 16'h0400 + 16'(i), 8'(i), 8'h00, 0, 0);
        apply_stimulus(1, 1, 8'h00, 16'h0500, 8'hEE, 8'h00, 1, 0);
        check_output("t5_count", fifo_count, 8);
        check_output("t5_overflow", overflow, 0);
        check_output("t5_pop_addr", slow_addr, 17'h00400);
        idle(1, 1);
        check_output("t5_busy_we", slow_we, 0);
        check_output("t5_busy_count", fifo_count, 8);
        for (int i = 0; i < 8; i++) idle(1, 0);
        check_output("t5_last_addr", slow_addr, 17'h00500);
        check_output("t5_last_din", slow_din, 8'hEE);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++)
            apply_stimulus(1, 1, 8'h01, 16'h2000 + 16'(i), 8'h90 + 8'(i), 8'h00, 0, 0);
        idle(1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(1, 0);
        check_output("t6_no_stale", slow_we, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ce_div = ((i / 400) % 2 == 0) ? 7 : 1;
            case ($urandom_range(0, 6))
                0: ra = 16'h0400 + 16'($urandom_range(0, 'h3FF));
                1: ra = 16'h0800 + 16'($urandom_range(0, 'h3FF));
                2: ra = 16'h2000 + 16'($urandom_range(0, 'h1FFF));
                3: ra = 16'h4000 + 16'($urandom_range(0, 'h1FFF));
                4: ra = 16'h6000 + 16'($urandom_range(0, 'h3FFF));
                5: ra = 16'h0C00 + 16'($urandom_range(0, 'h13FF));
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rb, ra, 8'($urandom),
                           8'($urandom) & 8'($urandom), $urandom_range(0, ce_div) == 0,
                           $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
